opb_register_simulink2ppc_snap: RTL and testbench
=================================================

Name: opb_register_simulink2ppc_snap

Overview:
OPB slave that lets the PowerPC read a 32-bit value produced by fabric logic. It captures `user_data_in` on each `user_valid` strobe into a snapshot register and tracks a new-data flag, a sticky overflow flag and a capture counter. All of these are exposed through a 4-word OPB window with single-beat acknowledged reads. Single clock domain: fabric logic driving this block runs on `OPB_Clk`.

Parameters:
C_BASEADDR, 32'h01003400, base address of the 256-byte window
C_HIGHADDR, 32'h010034FF, top address of the window
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width
C_FAMILY, "virtex5", target family (informational)

Ports:
OPB_Clk  in  1  sole clock
OPB_Rst  in  1  reset, asynchronous, active-low
OPB_ABus  in  [0:31]  OPB address
OPB_BE  in  [0:3]  byte enables, BE[3] = least-significant byte
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1=read, 0=write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  sequential hint, ignored
Sl_DBus  out  [0:31]  read data, zero when not acking a read
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
Sl_xferAck  out  1  transfer acknowledge
user_data_in  in  [31:0]  fabric value
user_valid  in  1  capture strobe, one cycle per sample

Behaviour:
- Reset (OPB_Rst=0, async) clears all of the following, independent of clock:
  - snap=0, new=0, ovf=0, cnt=0
  - Sl_xferAck=0, Sl_DBus=0
- Bit order: Sl_DBus[0] carries register bit 31 (MSB); Sl_DBus[31] carries bit 0. OPB_DBus uses the same mapping.
- Address hit: hit = OPB_select AND C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word select is OPB_ABus[28:29].
- Register map:
  - 0x0 DATA (RO): snap
  - 0x4 STATUS (RO): [31:16]=cnt, [1]=ovf, [0]=new, rest 0
  - 0x8 CTRL (WO): bit0=1 clears ovf; bit1=1 clears cnt. Honoured only when BE[3]=1. Reads 0.
  - 0xC: reads 0, writes ignored
- Handshake:
  - ack_next = hit AND NOT Sl_xferAck. Sl_xferAck is registered ack_next.
  - Result: a one-cycle pulse in the cycle after hit is sampled. Held select gives an ack every second cycle; each ack is a separate transfer.
  - On a read ack, Sl_DBus carries the register value sampled in the hit cycle (registered alongside ack). Otherwise Sl_DBus=0.
  - A write takes effect in the ack cycle (registered with ack).
  - Read latency: 1 cycle from select to ack.
- Capture (every cycle with user_valid=1):
  - snap <= user_data_in
  - cnt <= cnt+1, wrapping 0xFFFF -> 0x0000 with no flag
  - if new=1 already, ovf <= 1 (sticky)
  - new <= 1
- DATA read consumption: new clears in the cycle Sl_xferAck asserts for a DATA read. A STATUS read does not clear new.
- Simultaneous events:
  - user_valid in the same cycle as a DATA-read ack: capture wins, so new stays 1 and ovf is unchanged. The returned data is the pre-capture snap.
  - user_valid in the same cycle as a CTRL ovf-clear with new=1: the set wins, ovf=1.
  - user_valid in the same cycle as a CTRL cnt-clear: cnt=1.
- Outside the window: no ack, no state change, Sl_DBus=0.
- Reset mid-transfer: the ack is dropped immediately. The master times out; no recovery logic is required.

Test Plan:
1. Reset, then read 0x0 and 0x4 -> both acks carry 0x00000000. Sl_xferAck is high for exactly 1 cycle, arriving 1 cycle after select.
2. Pulse user_valid with 0xDEADBEEF, then read 0x4 -> 0x00010001. Then read 0x0 -> 0xDEADBEEF (Sl_DBus[0:7]=0xDE). Then read 0x4 -> 0x00010000.
3. Three user_valid pulses (1, 2, 3) with no read -> STATUS=0x00030003, DATA=3. Write 0x1 to 0x8 with BE=0b0001 -> STATUS=0x00030001. Write 0x2 with BE=0b1110 -> no change.
4. Assert user_valid=0x55 in the DATA read-ack cycle, with a prior snap of 0x44 and new=1 -> read returns 0x44; afterwards new=1 and ovf=0.
5. Hold OPB_select for 6 cycles at 0x0 -> exactly 3 ack pulses, alternating cycles. An address of C_HIGHADDR+4 -> no ack for 10 cycles.
6. 65536 user_valid pulses -> cnt=0x0000. Assert OPB_Rst low mid-read -> Sl_xferAck and all state zero before the next clock edge.

Source files
------------

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave exposing a fabric-captured 32-bit snapshot, new/overflow flags and a
// capture counter through a 4-word read window with single-beat acknowledged transfers.
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0]  C_BASEADDR   = 32'h01003400,
    parameter logic [31:0]  C_HIGHADDR   = 32'h010034FF,
    parameter int unsigned  C_OPB_AWIDTH = 32,
    parameter int unsigned  C_OPB_DWIDTH = 32,
    parameter               C_FAMILY     = "virtex5"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic                      Sl_xferAck,
    input  logic [31:0]               user_data_in,
    input  logic                      user_valid
);

    localparam int unsigned DW    = C_OPB_DWIDTH;
    localparam int unsigned AW    = C_OPB_AWIDTH;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] WORD_DATA   = 2'd0;
    localparam logic [1:0] WORD_STATUS = 2'd1;
    localparam logic [1:0] WORD_CTRL   = 2'd2;

    localparam bit unused_family = (C_FAMILY == "");

    logic [31:0]      snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             new_q, new_d;
    logic             ovf_q, ovf_d;
    logic             ack_q, ack_d;
    logic [DW-1:0]    dbus_q, dbus_d;

    logic             hit_c;
    logic             xfer_c;
    logic [1:0]       word_c;
    logic             data_rd_c;
    logic             ctrl_wr_c;
    logic             clr_ovf_c;
    logic             clr_cnt_c;
    logic [31:0]      rd_val_c;
    logic             unused_c;

    assign unused_c = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:DW-3],
                        OPB_ABus[0:AW-5], OPB_ABus[AW-2:AW-1]};

    // Address decode and transfer qualification; a held select acks every other cycle
    always_comb begin
        hit_c     = OPB_select &&
                    (OPB_ABus >= AW'(C_BASEADDR)) && (OPB_ABus <= AW'(C_HIGHADDR));
        xfer_c    = hit_c && !ack_q;
        word_c    = OPB_ABus[AW-4:AW-3];
        data_rd_c = xfer_c && OPB_RNW && (word_c == WORD_DATA);
        ctrl_wr_c = xfer_c && !OPB_RNW && (word_c == WORD_CTRL) && OPB_BE[3];
        clr_ovf_c = ctrl_wr_c && OPB_DBus[DW-1];
        clr_cnt_c = ctrl_wr_c && OPB_DBus[DW-2];
    end

    // Read mux; the OPB bus is big-endian so register bit 31 lands on Sl_DBus[0]
    always_comb begin
        rd_val_c = 32'd0;
        case (word_c)
            WORD_DATA:   rd_val_c = snap_q;
            WORD_STATUS: rd_val_c = {cnt_q, 14'd0, ovf_q, new_q};
            default:     rd_val_c = 32'd0;
        endcase
        ack_d  = xfer_c;
        dbus_d = (xfer_c && OPB_RNW) ? DW'(rd_val_c) : '0;
    end

    // Capture path; a capture overrides read consumption and ctrl clears in the same cycle
    always_comb begin
        snap_d = snap_q;
        cnt_d  = clr_cnt_c ? '0 : cnt_q;
        ovf_d  = clr_ovf_c ? 1'b0 : ovf_q;
        new_d  = new_q;
        if (user_valid) begin
            snap_d = user_data_in;
            cnt_d  = cnt_d + CNT_W'(1);
            new_d  = 1'b1;
            if (new_q && !data_rd_c) begin
                ovf_d = 1'b1;
            end
        end else if (data_rd_c) begin
            new_d = 1'b0;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            snap_q <= '0;
            cnt_q  <= '0;
            new_q  <= 1'b0;
            ovf_q  <= 1'b0;
            ack_q  <= 1'b0;
            dbus_q <= '0;
        end else begin
            snap_q <= snap_d;
            cnt_q  <= cnt_d;
            new_q  <= new_d;
            ovf_q  <= ovf_d;
            ack_q  <= ack_d;
            dbus_q <= dbus_d;
        end
    end

    assign Sl_xferAck = ack_q;
    assign Sl_DBus    = dbus_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Self-checking bench for the OPB snapshot register: directed scenarios plus a
// randomized mix of captures and bus transfers checked against a register-level model.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE = 32'h01003400;
    localparam logic [31:0] HIGH = 32'h010034FF;

    logic        clk;
    logic        rst_n;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic        Sl_xferAck;
    logic [31:0] user_data_in;
    logic        user_valid;

    int          n_checks;
    int          n_errors;

    // Reference model state
    logic [31:0] m_snap;
    logic        m_new;
    logic        m_ovf;
    logic [15:0] m_cnt;
    logic [0:31] last_rd;

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst_n),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .Sl_xferAck   (Sl_xferAck),
        .user_data_in (user_data_in),
        .user_valid   (user_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_snap = '0;
        m_new  = 1'b0;
        m_ovf  = 1'b0;
        m_cnt  = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] word);
        case (word)
            2'd0:    return m_snap;
            2'd1:    return {m_cnt, 14'd0, m_ovf, m_new};
            default: return 32'd0;
        endcase
    endfunction

    // One-cycle event applied to the model: optional bus transfer plus optional capture
    task automatic model_step(input bit bus, input bit rnw, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input bit cap, input logic [31:0] cap_val);
        bit data_rd;
        data_rd = bus && rnw && (addr[3:2] == 2'd0);
        if (bus && !rnw && addr[3:2] == 2'd2 && be[0]) begin
            if (wdata[0]) m_ovf = 1'b0;
            if (wdata[1]) m_cnt = '0;
        end
        if (cap) begin
            if (m_new && !data_rd) m_ovf = 1'b1;
            m_new  = 1'b1;
            m_snap = cap_val;
            m_cnt  = m_cnt + 16'd1;
        end else if (data_rd) begin
            m_new = 1'b0;
        end
    endtask

    task automatic capture(input logic [31:0] v);
        user_valid   = 1'b1;
        user_data_in = v;
        tick();
        user_valid   = 1'b0;
        model_step(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1, v);
    endtask

    // Single OPB transfer with an optional capture in the same (hit) cycle
    task automatic xfer(input bit rnw, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input bit cap, input logic [31:0] cap_val);
        bit          in_win;
        logic [31:0] exp_rd;
        in_win       = (addr >= BASE) && (addr <= HIGH);
        exp_rd       = model_read(addr[3:2]);
        OPB_select   = 1'b1;
        OPB_RNW      = rnw;
        OPB_ABus     = addr;
        OPB_BE       = be;
        OPB_DBus     = wdata;
        user_valid   = cap;
        user_data_in = cap_val;
        #3;
        check_eq("ack_before_edge", 32'(Sl_xferAck), 32'd0);
        tick();
        last_rd = Sl_DBus;
        check_eq("ack", 32'(Sl_xferAck), 32'(in_win));
        check_eq("rdata", Sl_DBus, (in_win && rnw) ? exp_rd : 32'd0);
        model_step(in_win, rnw, addr, be, wdata, cap, cap_val);
        OPB_select = 1'b0;
        user_valid = 1'b0;
        tick();
        check_eq("ack_one_cycle", 32'(Sl_xferAck), 32'd0);
    endtask

    initial begin
        int          acks;
        logic [31:0] addr;
        logic [31:0] r;
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        OPB_ABus     = '0;
        OPB_BE       = '0;
        OPB_DBus     = '0;
        OPB_RNW      = 1'b1;
        OPB_select   = 1'b0;
        OPB_seqAddr  = 1'b0;
        user_data_in = '0;
        user_valid   = 1'b0;
        last_rd      = '0;
        model_reset();

        #12;
        check_eq("rst_ack", 32'(Sl_xferAck), 32'd0);
        check_eq("rst_dbus", Sl_DBus, 32'd0);
        rst_n = 1'b1;
        tick();

        // Post-reset reads
        xfer(1'b1, BASE + 32'h0, 4'hF, 32'd0, 1'b0, 32'd0);
        check_eq("t1_data", last_rd, 32'h0);
        xfer(1'b1, BASE + 32'h4, 4'hF, 32'd0, 1'b0, 32'd0);
        check_eq("t1_status", last_rd, 32'h0);

        // Single capture and consumption
        capture(32'hDEADBEEF);
        xfer(1'b1, BASE + 32'h4, 4'hF, 32'd0, 1'b0, 32'd0);
        check_eq("t2_status_new", last_rd, 32'h00010001);
        xfer(1'b1, BASE + 32'h0, 4'hF, 32'd0, 1'b0, 32'd0);
        check_eq("t2_data", last_rd, 32'hDEADBEEF);
        check_eq("t2_msb_byte", 32'(last_rd[0:7]), 32'hDE);
        xfer(1'b1, BASE + 32'h4, 4'hF, 32'd0, 1'b0, 32'd0);
        check_eq("t2_status_clr", last_rd, 32'h00010000);

        // Overflow, ctrl clear and byte-enable gating
        model_step(1'b1, 1'b0, BASE + 32'h8, 4'b0001, 32'h2, 1'b0, 32'd0);
        xfer(1'b0, BASE + 32'h8, 4'b0001, 32'h2, 1'b0, 32'd0);
        capture(32'd1);
        capture(32'd2);
        capture(32'd3);
        xfer(1'b1, BASE + 32'h4, 4'hF, 32'd0, 1'b0, 32'd0);
        check_eq("t3_status", last_rd, 32'h00030003);
        xfer(1'b0, BASE + 32'h8, 4'b0001, 32'h1, 1'b0, 32'd0);
        xfer(1'b1, BASE + 32'h4, 4'hF, 32'd0, 1'b0, 32'd0);
        check_eq("t3_ovf_clr", last_rd, 32'h00030001);
        xfer(1'b0, BASE + 32'h8, 4'b1110, 32'h2, 1'b0, 32'd0);
        xfer(1'b1, BASE + 32'h4, 4'hF, 32'd0, 1'b0, 32'd0);
        check_eq("t3_be_gated", last_rd, 32'h00030001);
        xfer(1'b1, BASE + 32'h0, 4'hF, 32'd0, 1'b0, 32'd0);
        check_eq("t3_data", last_rd, 32'h3);

        // Capture colliding with a DATA read
        xfer(1'b0, BASE + 32'h8, 4'b0001, 32'h3, 1'b0, 32'd0);
        capture(32'h44);
        xfer(1'b1, BASE + 32'h0, 4'hF, 32'd0, 1'b1, 32'h55);
        check_eq("t4_data_old", last_rd, 32'h44);
        xfer(1'b1, BASE + 32'h4, 4'hF, 32'd0, 1'b0, 32'd0);
        check_eq("t4_status", last_rd, 32'h00020001);
        xfer(1'b1, BASE + 32'h0, 4'hF, 32'd0, 1'b0, 32'd0);
        check_eq("t4_data_new", last_rd, 32'h55);

        // Held select: ack on alternating cycles
        capture(32'hA5A5_0001);
        OPB_select = 1'b1;
        OPB_RNW    = 1'b1;
        OPB_ABus   = BASE;
        acks       = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("hold_ack", 32'(Sl_xferAck), 32'((i % 2) == 0));
            if (Sl_xferAck) begin
                acks++;
                check_eq("hold_rdata", Sl_DBus, m_snap);
                model_step(1'b1, 1'b1, BASE, 4'hF, 32'd0, 1'b0, 32'd0);
            end
        end
        OPB_select = 1'b0;
        tick();
        check_eq("hold_ack_count", 32'(acks), 32'd3);

        // Out-of-window select never acks
        OPB_select = 1'b1;
        OPB_ABus   = HIGH + 32'd4;
        acks       = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (Sl_xferAck) acks++;
        end
        OPB_select = 1'b0;
        tick();
        check_eq("oow_ack_count", 32'(acks), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            case ($urandom_range(0, 5))
                0: capture($urandom);
                1, 2: xfer(1'b1, BASE + (r & 32'hFC), 4'hF, 32'd0, r[8], $urandom);
                3: xfer(1'b0, BASE + 32'h8 + (r & 32'hF0), 4'(r[15:12]), 32'(r[1:0]),
                        r[9], $urandom);
                4: xfer(1'b0, BASE + (r & 32'hFC), 4'hF, $urandom, 1'b0, 32'd0);
                default: begin
                    addr = r[10] ? HIGH + 32'd1 + 32'(r[7:0]) : BASE - 32'd1 - 32'(r[7:0]);
                    xfer(r[11], addr, 4'hF, 32'h3, r[12], $urandom);
                end
            endcase
        end
        xfer(1'b1, BASE + 32'h4, 4'hF, 32'd0, 1'b0, 32'd0);
        xfer(1'b1, BASE + 32'h0, 4'hF, 32'd0, 1'b0, 32'd0);

        // Counter wrap after 65536 captures
        xfer(1'b0, BASE + 32'h8, 4'b0001, 32'h3, 1'b0, 32'd0);
        user_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            user_data_in = 32'(i);
            tick();
            model_step(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 32'(i));
        end
        user_valid = 1'b0;
        xfer(1'b1, BASE + 32'h4, 4'hF, 32'd0, 1'b0, 32'd0);
        check_eq("t6_wrap_status", last_rd, 32'h00000003);

        // Asynchronous reset during an acknowledged read
        OPB_select = 1'b1;
        OPB_RNW    = 1'b1;
        OPB_ABus   = BASE + 32'h4;
        tick();
        check_eq("rst_mid_ack_pre", 32'(Sl_xferAck), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ack", 32'(Sl_xferAck), 32'd0);
        check_eq("rst_mid_dbus", Sl_DBus, 32'd0);
        OPB_select = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        tick();
        xfer(1'b1, BASE + 32'h4, 4'hF, 32'd0, 1'b0, 32'd0);
        check_eq("rst_status", last_rd, 32'h0);
        xfer(1'b1, BASE + 32'h0, 4'hF, 32'd0, 1'b0, 32'd0);
        check_eq("rst_data", last_rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
